des_round_ctrl: RTL and testbench
=================================

DES_ROUND_CTRL -- requirements
Module: des_round_ctrl

Interface
REQ-001 Parameter: ROUNDS, default 16, rounds per DES pass; the round counter is 4 bits wide.
REQ-002 Port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 Port: n_rst  input  1  reset, asynchronous, active-high: 1 = in reset.
REQ-004 Port: in_valid  input  1  requester presents a block.
REQ-005 Port: in_ready  output  1  controller can accept a block.
REQ-006 Port: in_block  input  64  post-IP block {L0[63:32], R0[31:0]}.
REQ-007 Port: triple  input  1  0 = single DES (1 pass), 1 = Triple DES EDE (3 passes); sampled at accept.
REQ-008 Port: decrypt  input  1  0 = encrypt, 1 = decrypt; sampled at accept.
REQ-009 Port: re_out  output  32  right half driven to the expansion/f-function datapath.
REQ-010 Port: f_in  input  32  combinational f(R,K) result returned by the datapath in the same cycle.
REQ-011 Port: key_sel  output  2  key bank select: 0 = K1, 1 = K2, 2 = K3; 3 is never driven.
REQ-012 Port: round_idx  output  4  subkey index for the key schedule.
REQ-013 Port: out_valid  output  1  result available.
REQ-014 Port: out_ready  input  1  consumer accepts the result.
REQ-015 Port: out_block  output  64  pre-FP result.
REQ-016 Port: busy  output  1  high when the FSM state is not IDLE.

Function
REQ-017 The FSM SHALL have three states: IDLE, ROUND and DONE.
REQ-018 in_ready SHALL equal (state==IDLE).
REQ-019 Accept occurs on in_valid & in_ready. At accept:
- L <= in_block[63:32] and R <= in_block[31:0].
- triple and decrypt are latched.
- round and pass counters clear to 0.
- state <= ROUND.
REQ-020 in_valid while not in IDLE SHALL be ignored; no state change results.
REQ-021 re_out SHALL equal the R register at all times.
REQ-022 In ROUND, each cycle SHALL perform exactly one round:
- Rounds 0..14 of a pass: L <= R, R <= L ^ f_in.
- Round 15 of a pass: L <= L ^ f_in, R unchanged (no swap).
REQ-023 At the end of round 15, if the pass is not the last: pass++ and round <= 0; otherwise state <= DONE.
REQ-024 Pass direction SHALL follow the latched mode:
- Single DES: direction = decrypt.
- Triple DES encrypt: passes E,D,E.
- Triple DES decrypt: passes D,E,D.
REQ-025 key_sel per pass:
- Single DES: K1.
- Triple DES encrypt: K1, K2, K3.
- Triple DES decrypt: K3, K2, K1.
REQ-026 round_idx SHALL be the round count for an E pass and 15 minus the round count for a D pass.
REQ-027 In IDLE and DONE, key_sel and round_idx SHALL be 0.
REQ-028 out_block SHALL equal {L,R} at all times.
REQ-029 out_valid SHALL equal (state==DONE).
REQ-030 Latency from the accept edge to out_valid high SHALL be exactly 16 cycles (single) or 48 cycles (triple).
REQ-031 In DONE, out_block and out_valid SHALL hold while out_ready is 0.
REQ-032 On out_valid & out_ready, state <= IDLE; in_ready becomes 1 the next cycle, with no same-cycle accept in DONE.
REQ-033 Changes on triple or decrypt after accept SHALL NOT affect the operation in progress.

Reset
REQ-034 While n_rst=1, the block SHALL asynchronously force:
- state = IDLE, L = R = 0, round = pass = 0.
- latched triple and decrypt = 0.
- out_valid = 0, busy = 0, in_ready = 1.
- out_block = 0, re_out = 0, key_sel = 0, round_idx = 0.
REQ-035 Reset asserted mid-operation SHALL abort the operation; no out_valid pulse SHALL follow the release of reset.

Verification
REQ-036 Single encrypt, f_in tied 0, in_block=0x0123456789ABCDEF -> out_valid exactly 16 cycles after accept, out_block=0x89ABCDEF01234567, round_idx stepping 0..15, key_sel=0.
REQ-037 Triple encrypt, f_in tied 0, same input -> out_valid at cycle 48, out_block=0x89ABCDEF01234567, key_sel 0,1,2 over 16 cycles each, round_idx 0..15, 15..0, 0..15.
REQ-038 Triple decrypt, f_in driven by a bench f/key-schedule model with FIPS 46-3 style keys -> decrypting the encrypt output restores the original input; key_sel sequence 2,1,0.
REQ-039 Backpressure: out_ready=0 for 5 cycles in DONE -> out_block stable, out_valid high, in_ready=0, a new in_valid ignored; out_ready=1 -> IDLE next cycle.
REQ-040 Reset pulse at round 7 of pass 1 -> all outputs at reset values immediately (asynchronous); after release, in_ready=1 and no spurious out_valid.
REQ-041 f_in = re_out (bench loopback), single decrypt -> out_block matches the bench model; round_idx runs 15..0.

Source files
------------

// File: rtl/des_round_ctrl.sv
// des_round_ctrl: iterative DES/3DES-EDE round sequencer driving an external f-function datapath.
module des_round_ctrl #(
  parameter int ROUNDS = 16
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_block,
  input  logic        triple,
  input  logic        decrypt,
  output logic [31:0] re_out,
  input  logic [31:0] f_in,
  output logic [1:0]  key_sel,
  output logic [3:0]  round_idx,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_block,
  output logic        busy
);
  localparam logic [3:0] LAST = 4'(ROUNDS - 1);
  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;
  state_t      state;
  logic [31:0] l, r;
  logic [3:0]  rnd;
  logic [1:0]  pass;
  logic        trip, dec, dir, last_rnd, last_pass;
  // EDE: the middle pass runs opposite to the outer two
  assign dir       = trip ? dec ^ (pass == 2'd1) : dec;
  assign last_rnd  = rnd == LAST;
  assign last_pass = trip ? pass == 2'd2 : 1'b1;
  always_ff @(posedge clk or posedge n_rst)
    if (n_rst) begin
      state <= IDLE;
      l     <= '0;
      r     <= '0;
      rnd   <= '0;
      pass  <= '0;
      trip  <= 1'b0;
      dec   <= 1'b0;
    end else
      case (state)
        IDLE: if (in_valid) begin
          l     <= in_block[63:32];
          r     <= in_block[31:0];
          trip  <= triple;
          dec   <= decrypt;
          rnd   <= '0;
          pass  <= '0;
          state <= ROUND;
        end
        ROUND: begin
          if (last_rnd) l <= l ^ f_in;
          else begin
            l <= r;
            r <= l ^ f_in;
          end
          rnd <= last_rnd ? 4'd0 : rnd + 4'd1;
          if (last_rnd && last_pass) state <= DONE;
          if (last_rnd && !last_pass) pass <= pass + 2'd1;
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
  assign in_ready  = state == IDLE;
  assign busy      = state != IDLE;
  assign out_valid = state == DONE;
  assign re_out    = r;
  assign out_block = {l, r};
  assign key_sel   = state != ROUND || !trip ? 2'd0 : dec ? 2'd2 - pass : pass;
  assign round_idx = state != ROUND ? 4'd0 : dir ? LAST - rnd : rnd;
endmodule

// File: tb/tb_des_round_ctrl.sv
// tb_des_round_ctrl: directed checks of the DES round controller with zero, keyed and loopback f-functions.
module tb_des_round_ctrl;
  logic        clk = 1'b0, n_rst = 1'b1, in_valid = 1'b0, in_ready, triple = 1'b0, decrypt = 1'b0;
  logic [63:0] in_block = '0, out_block;
  logic [31:0] re_out, f_in;
  logic [1:0]  key_sel, fmode = 2'd0;
  logic [3:0]  round_idx;
  logic        out_valid, out_ready = 1'b0, busy;
  int          n_cmp = 0, n_err = 0;
  localparam logic [63:0] K1 = 64'h133457799BBCDFF1, K2 = 64'h0E329232EA6D0D73, K3 = 64'hAABB09182736CCDD;
  localparam logic [63:0] P  = 64'h0123456789ABCDEF, SW = 64'h89ABCDEF01234567;

  des_round_ctrl dut (
    .clk(clk), .n_rst(n_rst), .in_valid(in_valid), .in_ready(in_ready), .in_block(in_block),
    .triple(triple), .decrypt(decrypt), .re_out(re_out), .f_in(f_in), .key_sel(key_sel),
    .round_idx(round_idx), .out_valid(out_valid), .out_ready(out_ready), .out_block(out_block), .busy(busy)
  );

  always #5 clk = ~clk;

  // toy keyed f: any f keeps the Feistel network invertible, which is all the round trip needs
  function automatic logic [31:0] fm(input logic [31:0] x, input logic [1:0] ks, input logic [3:0] idx);
    logic [63:0] k;
    logic [31:0] sub;
    k   = ks == 2'd0 ? K1 : ks == 2'd1 ? K2 : K3;
    sub = (k[63:32] << idx) ^ (k[63:32] >> (6'd32 - {2'b0, idx})) ^ k[31:0] ^ {28'b0, idx};
    return {x[26:0], x[31:27]} ^ sub ^ (x + sub);
  endfunction

  always_comb f_in = fmode == 2'd2 ? re_out : fmode == 2'd1 ? fm(re_out, key_sel, round_idx) : 32'd0;

  function automatic logic [1:0] exp_ks(input bit t, input bit d, input int p);
    return !t ? 2'd0 : d ? 2'(2 - p) : 2'(p);
  endfunction

  function automatic bit exp_dir(input bit t, input bit d, input int p);
    return !t ? d : (p == 1) ? !d : d;
  endfunction

  function automatic logic [63:0] mpass(input logic [63:0] b, input logic [1:0] m, input logic [1:0] ks, input bit dr);
    logic [31:0] l, r, f;
    logic [3:0]  idx;
    l = b[63:32];
    r = b[31:0];
    for (int i = 0; i < 16; i++) begin
      idx = dr ? 4'(15 - i) : 4'(i);
      f   = m == 2'd2 ? r : m == 2'd1 ? fm(r, ks, idx) : 32'd0;
      if (i < 15) {l, r} = {r, l ^ f};
      else l = l ^ f;
    end
    return {l, r};
  endfunction

  function automatic logic [63:0] model(input logic [63:0] b, input logic [1:0] m, input bit t, input bit d);
    logic [63:0] x;
    x = b;
    for (int p = 0; p < (t ? 3 : 1); p++) x = mpass(x, m, exp_ks(t, d, p), exp_dir(t, d, p));
    return x;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_out_block"}, out_block, 64'd0);
    chk({tag, "_re_out"}, {32'd0, re_out}, 64'd0);
    chk({tag, "_out_valid"}, {63'd0, out_valid}, 64'd0);
    chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
    chk({tag, "_in_ready"}, {63'd0, in_ready}, 64'd1);
    chk({tag, "_key_sel"}, {62'd0, key_sel}, 64'd0);
    chk({tag, "_round_idx"}, {60'd0, round_idx}, 64'd0);
  endtask

  task automatic run(input logic [63:0] blk, input bit t, input bit d, input logic [1:0] m,
                     input logic [63:0] exp, input int hold);
    int n;
    n = t ? 48 : 16;
    @(negedge clk);
    fmode = m; in_block = blk; triple = t; decrypt = d; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0; triple = !t; decrypt = !d; in_block = ~blk;
    for (int k = 0; k < n; k++) begin
      chk("valid_early", {63'd0, out_valid}, 64'd0);
      chk("key_sel", {62'd0, key_sel}, {62'd0, exp_ks(t, d, k / 16)});
      chk("round_idx", {60'd0, round_idx}, {60'd0, exp_dir(t, d, k / 16) ? 4'(15 - k % 16) : 4'(k % 16)});
      @(negedge clk);
    end
    chk("valid_at_latency", {63'd0, out_valid}, 64'd1);
    chk("result", out_block, exp);
    chk("done_in_ready", {63'd0, in_ready}, 64'd0);
    chk("done_busy", {63'd0, busy}, 64'd1);
    chk("done_key_sel", {62'd0, key_sel}, 64'd0);
    chk("done_round_idx", {60'd0, round_idx}, 64'd0);
    in_valid = 1'b1;
    in_block = 64'hDEADBEEFCAFEF00D;
    repeat (hold) begin
      @(negedge clk);
      chk("hold_block", out_block, exp);
      chk("hold_valid", {63'd0, out_valid}, 64'd1);
      chk("hold_in_ready", {63'd0, in_ready}, 64'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("release_valid", {63'd0, out_valid}, 64'd0);
    chk("release_in_ready", {63'd0, in_ready}, 64'd1);
    chk("release_busy", {63'd0, busy}, 64'd0);
    chk("release_block", out_block, exp);
  endtask

  initial begin
    logic [63:0] c;
    bit          seen;
    #1 chk_reset_outputs("reset");
    repeat (2) @(negedge clk);
    n_rst = 1'b0;
    run(P, 1'b0, 1'b0, 2'd0, SW, 5);
    run(P, 1'b1, 1'b0, 2'd0, SW, 0);
    c = model(P, 2'd1, 1'b1, 1'b0);
    run(P, 1'b1, 1'b0, 2'd1, c, 1);
    run(c, 1'b1, 1'b1, 2'd1, P, 0);
    run(P, 1'b0, 1'b1, 2'd2, model(P, 2'd2, 1'b0, 1'b1), 0);
    @(negedge clk);
    fmode = 2'd1; in_block = P; triple = 1'b1; decrypt = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (23) @(negedge clk);
    chk("midop_key_sel", {62'd0, key_sel}, 64'd1);
    chk("midop_round_idx", {60'd0, round_idx}, 64'd8);
    n_rst = 1'b1;
    #1 chk_reset_outputs("async_reset");
    @(negedge clk);
    n_rst = 1'b0;
    seen = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("no_spurious_valid", {63'd0, seen}, 64'd0);
    chk("post_reset_in_ready", {63'd0, in_ready}, 64'd1);
    run(64'hFEDCBA9876543210, 1'b0, 1'b0, 2'd1, model(64'hFEDCBA9876543210, 2'd1, 1'b0, 1'b0), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
